b7_rx_ctrl: RTL and testbench

Receive controller that sequences 7-bit serial character capture on the same line the 7-bit-to-ASCII deserializer uses. It detects a start bit and shifts 7 data bits MSB-first. It checks the stop bit, then queues good characters in a small FIFO that a downstream consumer drains with a valid/ready handshake. It sits between the raw serial pin and any character consumer, such as a display or command parser.

---
 rtl/b7_rx_pkg.sv | 21 ++
 rtl/b7_rx_fifo.sv | 56 +++++
 rtl/b7_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_b7_rx_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/b7_rx_pkg.sv
// Shared types and constants for the 7-bit serial receive controller.
package b7_rx_pkg;

  localparam int CW = 7;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic evenParity(input logic [CW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/b7_rx_fifo.sv
// Small character FIFO between the receive FSM and the downstream consumer.
// Head output reads as zero whenever the FIFO is empty.
module b7_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [CW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [CW-1:0]            head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [CW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q;
  logic [AW-1:0]   rdPtr_q;
  logic [CNTW-1:0] count_q;
  logic            doPush;
  logic            doPop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (doPush && !doPop)      count_q <= count_q + CNTW'(1);
      else if (doPop && !doPush) count_q <= count_q - CNTW'(1);
    end
  end

  // Storage needs no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/b7_rx_ctrl.sv
// Receive controller: start-bit detection, MSB-first 7-bit capture, stop-bit
// check and buffering of good characters for a valid/ready consumer.
// Optional even-parity bit between data and stop: define B7_RX_PARITY_EN.
module b7_rx_ctrl
  import b7_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in,
  input  logic                   en,
  output logic [CW-1:0]          char_out,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef B7_RX_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(CW - 1);

  state_e        state_q;
  logic [CW-1:0] shift_q;
  logic [CW-1:0] shift_d;
  logic [2:0]    cnt_q;
  logic          frameErr_q;
  logic          overflow_q;
  logic          charGood;
  logic          pop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          dropChar;
`ifdef B7_RX_PARITY_EN
  logic          parBad_q;
  logic          parityErr_q;
`endif

  assign shift_d = {shift_q[CW-2:0], in};

`ifdef B7_RX_PARITY_EN
  assign charGood = (state_q == STOP) && (in == IDLE_LVL) && !parBad_q;
`else
  assign charGood = (state_q == STOP) && (in == IDLE_LVL);
`endif

  assign pop      = char_valid & char_ready;
  assign dropChar = charGood & fifoFull & ~pop;

  // Frame sequencing, data shifting and the registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      frameErr_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef B7_RX_PARITY_EN
      parBad_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      frameErr_q <= 1'b0;
`ifdef B7_RX_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      if (dropChar) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (en && (in == START_LVL)) begin
            state_q <= DATA;
            cnt_q   <= '0;
          end
        end
        DATA: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == LAST_BIT) begin
`ifdef B7_RX_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end
        end
`ifdef B7_RX_PARITY_EN
        PARITY: begin
          parBad_q <= (in != evenParity(shift_q));
          state_q  <= STOP;
        end
`endif
        STOP: begin
          frameErr_q <= (in == START_LVL);
`ifdef B7_RX_PARITY_EN
          parityErr_q <= parBad_q;
          parBad_q    <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  b7_rx_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (charGood),
    .data_i  (shift_q),
    .pop_i   (pop),
    .head_o  (char_out),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifo_count)
  );

  assign char_valid = ~fifoEmpty;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frameErr_q;
  assign overflow   = overflow_q;
`ifdef B7_RX_PARITY_EN
  assign parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_b7_rx_ctrl.sv
// Self-checking bench for b7_rx_ctrl: a queue-based model of the character
// buffer is compared against the DUT every cycle, plus literal spot checks.
module tb_b7_rx_ctrl;

  localparam int DEPTH = 4;
`ifdef B7_RX_PARITY_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serialIn = 1'b1;
  logic       rxEn = 1'b1;
  logic       charReady = 1'b0;
  logic [6:0] charOut;
  logic       charValid;
  logic       busy;
  logic       frameErr;
  logic       overflow;
  logic [2:0] fifoCount;
`ifdef B7_RX_PARITY_EN
  logic       parityErr;
`endif

  int nCompared = 0;
  int nMismatched = 0;
  bit checking = 1'b0;

  logic [6:0] expQ[$];
  bit         expOverflow = 1'b0;
  bit         expBusy = 1'b0;
  bit         expFrameErr = 1'b0;

  logic [6:0] drainFull[4];
  logic [6:0] drainSim[4];

  b7_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (serialIn),
    .en         (rxEn),
    .char_out   (charOut),
    .char_valid (charValid),
    .char_ready (charReady),
    .busy       (busy),
    .frame_err  (frameErr),
    .overflow   (overflow),
    .fifo_count (fifoCount)
`ifdef B7_RX_PARITY_EN
    ,
    .parity_err (parityErr)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit-time of inputs, then update the model at the sampling edge.
  task automatic applyStimulus(input logic inV, input logic enV, input logic rdyV, input logic rstV,
                               input bit busyAfter, input bit pushAttempt, input logic [6:0] ch,
                               input bit ferrAfter);
    logic [6:0] popped;
    @(negedge clk);
    serialIn  = inV;
    rxEn      = enV;
    charReady = rdyV;
    rst       = rstV;
    @(posedge clk);
    if (!rstV) begin
      expQ.delete();
      expOverflow = 1'b0;
      expBusy     = 1'b0;
      expFrameErr = 1'b0;
    end else begin
      if (rdyV && expQ.size() > 0) popped = expQ.pop_front();
      if (pushAttempt) begin
        if (expQ.size() >= DEPTH) expOverflow = 1'b1;
        else expQ.push_back(ch);
      end
      expBusy     = busyAfter;
      expFrameErr = ferrAfter;
    end
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, rdy, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
  endtask

  // Serial frame: start, 7 data bits MSB-first, optional parity, stop.
  task automatic sendFrame(input logic [6:0] ch, input bit stopBit, input int enDropAt,
                           input bit readyAtStop, input int rstAt);
    logic b;
    bit   last;
    for (int k = 0; k < FRAME_BITS; k++) begin
      last = (k == FRAME_BITS - 1);
      if (k == 0) b = 1'b0;
      else if (k <= 7) b = ch[7-k];
      else if (last) b = stopBit;
      else b = ^ch;
      if (k == rstAt) begin
        applyStimulus(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
        return;
      end
      applyStimulus(b, (enDropAt >= 0 && k >= enDropAt) ? 1'b0 : 1'b1,
                    last ? readyAtStop : 1'b0, 1'b1,
                    !last, last && stopBit, ch, last && !stopBit);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("char_valid", 32'(charValid), 32'(expQ.size() != 0));
      checkOutput("char_out", 32'(charOut), (expQ.size() != 0) ? 32'(expQ[0]) : 32'h0);
      checkOutput("fifo_count", 32'(fifoCount), 32'(expQ.size()));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("frame_err", 32'(frameErr), 32'(expFrameErr));
      checkOutput("overflow", 32'(overflow), 32'(expOverflow));
`ifdef B7_RX_PARITY_EN
      checkOutput("parity_err", 32'(parityErr), 32'h0);
`endif
    end
  end

  initial begin
    drainFull = '{7'h61, 7'h62, 7'h63, 7'h64};
    drainSim  = '{7'h71, 7'h72, 7'h73, 7'h74};

    // Reset with an idle line.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    checking = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    idleCycles(20, 1'b0);
    #1;
    checkOutput("lit_reset_count", 32'(fifoCount), 32'h0);
    checkOutput("lit_reset_valid", 32'(charValid), 32'h0);

    // Single 'A' held in the FIFO.
    sendFrame(7'h41, 1'b1, -1, 1'b0, -1);
    #1;
    checkOutput("lit_A_char", 32'(charOut), 32'h41);
    checkOutput("lit_A_count", 32'(fifoCount), 32'h1);
    checkOutput("lit_A_busy", 32'(busy), 32'h0);
    idleCycles(2, 1'b0);
    idleCycles(1, 1'b1);

    // Bad stop bit, then a good 'B'.
    sendFrame(7'h41, 1'b0, -1, 1'b0, -1);
    #1;
    checkOutput("lit_ferr_pulse", 32'(frameErr), 32'h1);
    checkOutput("lit_ferr_count", 32'(fifoCount), 32'h0);
    sendFrame(7'h42, 1'b1, -1, 1'b0, -1);
    #1;
    checkOutput("lit_B_char", 32'(charOut), 32'h42);
    idleCycles(2, 1'b1);

    // Five back-to-back frames into a four-entry FIFO.
    for (int i = 0; i < 5; i++) sendFrame(7'h61 + 7'(i), 1'b1, -1, 1'b0, -1);
    #1;
    checkOutput("lit_full_count", 32'(fifoCount), 32'h4);
    checkOutput("lit_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lit_drain_full", 32'(charOut), 32'(drainFull[i]));
      idleCycles(1, 1'b1);
      #1;
    end
    checkOutput("lit_drained", 32'(fifoCount), 32'h0);

    // Clear sticky overflow, fill, then push and pop together while full.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
    for (int i = 0; i < 4; i++) sendFrame(7'h70 + 7'(i), 1'b1, -1, 1'b0, -1);
    sendFrame(7'h74, 1'b1, -1, 1'b1, -1);
    #1;
    checkOutput("lit_sim_count", 32'(fifoCount), 32'h4);
    checkOutput("lit_sim_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("lit_drain_sim", 32'(charOut), 32'(drainSim[i]));
      idleCycles(1, 1'b1);
      #1;
    end

    // Enable dropped mid-frame does not abort it.
    sendFrame(7'h5A, 1'b1, 3, 1'b0, -1);
    #1;
    checkOutput("lit_endrop_char", 32'(charOut), 32'h5A);
    idleCycles(1, 1'b1);

    // Start bit ignored while enable is low.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0);
    idleCycles(2, 1'b0);

    // Reset mid-frame discards the partial character; next frame recovers.
    sendFrame(7'h43, 1'b1, -1, 1'b0, 4);
    idleCycles(3, 1'b0);
    #1;
    checkOutput("lit_rst_busy", 32'(busy), 32'h0);
    checkOutput("lit_rst_count", 32'(fifoCount), 32'h0);
    sendFrame(7'h44, 1'b1, -1, 1'b0, -1);
    idleCycles(2, 1'b1);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
